// File: rtl/sng_stream_ctrl.sv
// sng_stream_ctrl: seeds and steps a stochastic number generator, counting ones over a fixed-length stream
`ifndef BIN_LEN
`define BIN_LEN 4
`endif
module sng_stream_ctrl #(
  parameter int BIN_LEN    = `BIN_LEN,
  parameter int STREAM_LEN = 2**BIN_LEN,
  parameter int CNT_W      = BIN_LEN+1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BIN_LEN-1:0] in_val,
  input  logic               abort,
  output logic               sng_reset,
  output logic               sng_enable,
  output logic [BIN_LEN-1:0] sng_in_val,
  input  logic               sng_bit,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CNT_W-1:0]   out_count,
  output logic               busy
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEED = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(STREAM_LEN-1);
  logic [1:0]         state_q, state_d;
  logic [BIN_LEN-1:0] op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, smp_q, smp_d;
  logic               busy_q, busy_d;
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    smp_d   = smp_q;
    if (state_q == IDLE && in_valid) begin
      state_d = SEED;
      op_d    = in_val;
      cnt_d   = '0;
      smp_d   = '0;
    end else if (state_q == SEED) begin
      state_d = abort ? IDLE : RUN;
    end else if (state_q == RUN) begin
      cnt_d   = cnt_q + CNT_W'(sng_bit);
      smp_d   = smp_q + CNT_W'(1);
      state_d = abort ? IDLE : (smp_q == LAST ? DONE : RUN);
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      smp_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      smp_q   <= smp_d;
      busy_q  <= busy_d;
    end
  end
  // sng_reset follows reset combinationally so the SNG re-seeds alongside the controller
  assign sng_reset  = reset || state_q == SEED;
  assign sng_enable = state_q == RUN;
  assign sng_in_val = op_q;
  assign in_ready   = state_q == IDLE;
  assign out_valid  = state_q == DONE;
  assign out_count  = cnt_q;
  assign busy       = busy_q;
endmodule

// File: tb/tb_sng_stream_ctrl.sv
// tb_sng_stream_ctrl: randomized bench with a behavioural LFSR SNG and a stream-replay reference model
module tb_sng_stream_ctrl;
  localparam logic [3:0] SEED = 4'h9;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0, abort = 1'b0, out_ready = 1'b0;
  logic [3:0] in_val = 4'h0;
  logic       in_ready, sng_reset, sng_enable, sng_bit, out_valid, busy;
  logic [3:0] sng_in_val;
  logic [4:0] out_count;
  logic [3:0] lfsr = SEED;
  int         n_cmp = 0, n_err = 0;
  sng_stream_ctrl #(.BIN_LEN(4), .STREAM_LEN(16), .CNT_W(5)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_val(in_val),
    .abort(abort), .sng_reset(sng_reset), .sng_enable(sng_enable), .sng_in_val(sng_in_val),
    .sng_bit(sng_bit), .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count), .busy(busy)
  );
  always #5 clock = ~clock;
  function automatic logic [3:0] nxt(input logic [3:0] x);
    return {x[2:0], x[3] ^ x[2]};
  endfunction
  always_ff @(posedge clock) begin
    if (sng_reset) lfsr <= SEED;
    else if (sng_enable) lfsr <= nxt(lfsr);
  end
  assign sng_bit = lfsr <= sng_in_val;
  function automatic int model(input int v);
    logic [3:0] x = SEED;
    int c = 0;
    for (int k = 0; k < 16; k++) begin
      if (int'(x) <= v) c++;
      x = nxt(x);
    end
    return c;
  endfunction
  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clock);
    #1;
  endtask
  task automatic check_idle(input string tag);
    chk({tag, "_rdy"}, in_ready, 1);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_en"}, sng_enable, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_srst"}, sng_reset, 0);
  endtask
  task automatic check_reset(input string tag);
    chk({tag, "_rdy"}, in_ready, 1);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_en"}, sng_enable, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_cnt"}, out_count, 0);
    chk({tag, "_op"}, sng_in_val, 0);
    chk({tag, "_srst"}, sng_reset, 1);
  endtask
  task automatic accept(input int v);
    in_valid = 1'b1;
    in_val = 4'(v);
    step;
    in_valid = 1'b0;
    in_val = 4'($urandom);
    chk("seed_srst", sng_reset, 1);
    chk("seed_en", sng_enable, 0);
    chk("seed_rdy", in_ready, 0);
    chk("seed_busy", busy, 1);
    chk("seed_op", sng_in_val, v);
  endtask
  task automatic run_to_done(input int v, input bit noise);
    int en = 0, lat = 0;
    for (int i = 1; i <= 40 && lat == 0; i++) begin
      if (noise) begin
        in_valid = 1'($urandom);
        in_val = 4'($urandom);
      end
      step;
      if (out_valid) lat = i;
      else begin
        en += int'(sng_enable);
        chk("run_op", sng_in_val, v);
      end
    end
    in_valid = 1'b0;
    chk("run_len", en, 16);
    chk("latency", lat, 17);
    chk("count", out_count, model(v));
  endtask
  task automatic drain(input int v, input int hold, input bit noise);
    for (int i = 0; i < hold; i++) begin
      abort = noise ? 1'($urandom) : 1'b0;
      in_valid = noise ? 1'($urandom) : 1'b0;
      step;
      chk("hold_valid", out_valid, 1);
      chk("hold_count", out_count, model(v));
      chk("hold_en", sng_enable, 0);
      chk("hold_rdy", in_ready, 0);
    end
    abort = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    step;
    out_ready = 1'b0;
    chk("drain_rdy", in_ready, 1);
    chk("drain_valid", out_valid, 0);
    chk("drain_busy", busy, 0);
  endtask
  initial begin
    int seeds, ov, v;
    step;
    step;
    check_reset("por");
    reset = 1'b0;
    step;
    check_idle("idle0");
    accept(15);
    run_to_done(15, 1'b0);
    drain(15, 10, 1'b1);
    accept(0);
    run_to_done(0, 1'b0);
    drain(0, 1, 1'b0);
    accept(7);
    run_to_done(7, 1'b0);
    drain(7, 0, 1'b0);
    accept(15);
    repeat (5) step;
    chk("ab_run", sng_enable, 1);
    abort = 1'b1;
    step;
    abort = 1'b0;
    check_idle("abort_run");
    ov = 0;
    repeat (20) begin
      step;
      ov += int'(out_valid);
    end
    chk("abort_novalid", ov, 0);
    accept(15);
    abort = 1'b1;
    step;
    abort = 1'b0;
    check_idle("abort_seed");
    accept(15);
    run_to_done(15, 1'b0);
    drain(15, 0, 1'b0);
    accept(7);
    repeat (3) step;
    reset = 1'b1;
    abort = 1'b1;
    step;
    abort = 1'b0;
    check_reset("rst_run");
    reset = 1'b0;
    step;
    check_idle("post_rst_run");
    accept(9);
    run_to_done(9, 1'b0);
    reset = 1'b1;
    out_ready = 1'b1;
    step;
    out_ready = 1'b0;
    check_reset("rst_done");
    reset = 1'b0;
    step;
    check_idle("post_rst_done");
    accept(15);
    run_to_done(15, 1'b0);
    drain(15, 0, 1'b0);
    in_valid = 1'b1;
    in_val = 4'd5;
    step;
    chk("acc1_seed", sng_reset, 1);
    seeds = 0;
    for (int i = 0; i < 40 && !out_valid; i++) begin
      step;
      seeds += int'(sng_reset);
    end
    chk("no_reaccept", seeds, 0);
    chk("held_count", out_count, model(5));
    out_ready = 1'b1;
    step;
    out_ready = 1'b0;
    chk("hs_idle", in_ready, 1);
    step;
    chk("acc2_seed", sng_reset, 1);
    in_valid = 1'b0;
    run_to_done(5, 1'b0);
    drain(5, 0, 1'b0);
    repeat (8) begin
      v = int'($urandom_range(0, 15));
      accept(v);
      run_to_done(v, 1'b1);
      drain(v, int'($urandom_range(0, 4)), 1'b1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sng_stream_ctrl.md
SNG_STREAM_CTRL -- requirements
Module: sng_stream_ctrl

Interface
REQ-001 Parameter: BIN_LEN, default `BIN_LEN, width of the binary operand and of the SNG input.
REQ-002 Parameter: STREAM_LEN, default 2**BIN_LEN, number of stochastic bits sampled per conversion; legal range 1..2**BIN_LEN.
REQ-003 Parameter: CNT_W, default BIN_LEN+1, width of the ones-count result.
REQ-004 Port: clock  in  1  single clock; all state updates on its rising edge.
REQ-005 Port: reset  in  1  synchronous, active-high reset.
REQ-006 Port: in_valid  in  1  operand offered.
REQ-007 Port: in_ready  out  1  controller can accept an operand.
REQ-008 Port: in_val  in  BIN_LEN  binary operand to convert.
REQ-009 Port: abort  in  1  cancel the conversion in progress.
REQ-010 Port: sng_reset  out  1  drives SNG reset, which reloads the LFSR seed.
REQ-011 Port: sng_enable  out  1  drives SNG enable, which advances the LFSR.
REQ-012 Port: sng_in_val  out  BIN_LEN  operand presented to the SNG.
REQ-013 Port: sng_bit  in  1  SNG out_val, combinational from the current LFSR state.
REQ-014 Port: out_valid  out  1  result available.
REQ-015 Port: out_ready  in  1  consumer accepts the result.
REQ-016 Port: out_count  out  CNT_W  number of 1s sampled in the stream.
REQ-017 Port: busy  out  1  high in any state other than IDLE.

Function
REQ-018 The FSM SHALL have four states: IDLE, SEED, RUN, DONE.
REQ-019 In IDLE, in_ready SHALL be 1; in every other state it SHALL be 0.
REQ-020 In IDLE, when in_valid=1, the controller SHALL latch in_val into op_reg, clear the ones-count and the sample counter, and go to SEED.
REQ-021 In SEED (exactly 1 cycle), sng_reset SHALL be 1 and sng_enable SHALL be 0; the next state SHALL be RUN.
REQ-022 In RUN:
- sng_enable SHALL be 1 and sng_reset 0.
- Each cycle, sng_bit SHALL be sampled and added to the ones-count.
- The sample counter SHALL increment each cycle.
REQ-023 After exactly STREAM_LEN RUN cycles, the FSM SHALL go to DONE; the final sample SHALL be included in the count.
REQ-024 In DONE:
- out_valid SHALL be 1 and out_count SHALL hold stable.
- The FSM SHALL stay in DONE until out_valid and out_ready are both 1, then go to IDLE.
REQ-025 sng_in_val SHALL equal op_reg in every state; op_reg SHALL change only on an accepted input.
REQ-026 sng_enable SHALL be 0 in IDLE and DONE, and sng_reset SHALL be 0 outside SEED.
REQ-027 Latency: an input accepted at edge t SHALL produce SEED in cycle t+1, RUN in cycles t+2..t+1+STREAM_LEN, and out_valid=1 from cycle t+2+STREAM_LEN.
REQ-028 The ones-count SHALL NOT wrap: CNT_W holds STREAM_LEN exactly; out_count range is 0..STREAM_LEN.
REQ-029 abort=1 in SEED or RUN SHALL send the FSM to IDLE on the next edge, deassert sng_enable, and produce no out_valid.
REQ-030 abort SHALL be ignored in IDLE and DONE.
REQ-031 abort has priority over RUN completion in the same cycle.
REQ-032 in_valid SHALL be ignored outside IDLE; it has no queueing.
REQ-033 The same-cycle DONE handshake SHALL NOT also accept a new input; acceptance occurs the following cycle in IDLE.
REQ-034 busy SHALL be a registered function of state only.

Reset
REQ-035 reset=1 at a clock edge SHALL force:
- state to IDLE;
- op_reg, the ones-count, the sample counter and out_count to 0;
- out_valid, sng_enable and busy to 0;
- in_ready to 1.
REQ-036 While reset=1, sng_reset SHALL be 1, so the SNG is re-seeded together with the controller.
REQ-037 reset asserted in any state, including mid-RUN and DONE with out_valid pending, SHALL discard the conversion with no output.
REQ-038 reset SHALL take priority over abort and all handshakes.

Verification (BIN_LEN=4, STREAM_LEN=16, behavioural SNG with a maximal-length, nonzero 4-bit LFSR)
REQ-039 Scenario: in_val=15 accepted -> SEED 1 cycle, then sng_enable high for exactly 16 cycles -> out_valid in cycle t+18 with out_count=16; no counter wrap.
REQ-040 Scenario: in_val=0 -> out_count=0; in_val=7 -> out_count matches a reference model replaying the LFSR sequence from its seed.
REQ-041 Scenario: result held with out_ready=0 for 10 cycles -> out_valid and out_count stable, sng_enable=0, in_ready=0; out_ready=1 -> IDLE next cycle.
REQ-042 Scenario: abort in the 5th RUN cycle -> IDLE next edge, no out_valid; next conversion of in_val=15 -> 16.
REQ-043 Scenario: reset mid-RUN and reset in DONE -> all outputs at reset values the next cycle; next in_val=15 -> 16.
REQ-044 Scenario: in_valid held high continuously -> one accept per conversion; second accept exactly one cycle after the DONE handshake.
